// File: rtl/mycpu_arb_pkg.sv
// Shared definitions for the instruction/data SRAM-like port arbiter.
// Owner ids tag each accepted request so its response can be routed back.
// No ports; imported by arb_owner_fifo and sram_like_arbiter.
package mycpu_arb_pkg;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // Default depth of the owner FIFO (maximum accepted-but-unanswered requests).
    localparam int OUTSTANDING_DEF = 2;

endpackage

// File: rtl/arb_owner_fifo.sv
// Synchronous 1-bit-wide FIFO holding the owner id of each outstanding request.
// Latency: push visible at dout one cycle later when empty; pop takes effect next edge.
// Backpressure: push ignored when full, pop ignored when empty; a same-cycle pop never frees room for a push.
// Ports: clk, reset (sync, active-high), push/din, pop/dout, full, empty.
module arb_owner_fifo
    import mycpu_arb_pkg::*;
#(
    parameter int DEPTH = OUTSTANDING_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Fullness is judged on the registered count, so a pop cannot make room for a push in the same cycle.
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like req/addr_ok/data_ok port between the instruction and data masters.
// Latency: zero-cycle combinational pass-through for requests and responses; only owner ids are stored.
// Backpressure: m_req drops while the owner FIFO is full; a request waiting for m_addr_ok is locked to its owner.
// Ports: clk, reset (sync, active-high); inst_* and data_* master ports; m_* slave port.
// Build option: define ARB_ROUND_ROBIN_EN for alternating grants on ties (default: DATA has priority).
module sram_like_arbiter
    import mycpu_arb_pkg::*;
#(
    parameter int OUTSTANDING = OUTSTANDING_DEF,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [3:0]        inst_wen,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [ADDR_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [ADDR_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [ADDR_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [ADDR_W-1:0] data_rdata,
    output logic              m_req,
    output logic [3:0]        m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [ADDR_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [ADDR_W-1:0] m_rdata
);

    logic lock_q, lock_d;
    logic owner_q, owner_d;
    logic grant, owner, owner_req;
    logic accept, pop;
    logic fifo_full, fifo_empty, fifo_head;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;
`endif

    always_comb begin
        // Unlocked grant; grant only ever names a requesting master when one exists.
        grant = OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_req && data_req) begin
            grant = ~last_owner_q;
        end else if (data_req) begin
            grant = OWN_DATA;
        end
`else
        if (data_req) begin
            grant = OWN_DATA;
        end
`endif
        // A request already presented but not yet accepted keeps its owner.
        owner     = lock_q ? owner_q : grant;
        owner_req = (owner == OWN_DATA) ? data_req : inst_req;
        m_req     = owner_req & ~fifo_full & ~reset;
        accept    = m_req & m_addr_ok;

        m_wen   = (owner == OWN_DATA) ? data_wen   : inst_wen;
        m_addr  = (owner == OWN_DATA) ? data_addr  : inst_addr;
        m_wdata = (owner == OWN_DATA) ? data_wdata : inst_wdata;

        inst_addr_ok = accept & (owner == OWN_INST);
        data_addr_ok = accept & (owner == OWN_DATA);

        // A data_ok with nothing outstanding is dropped rather than routed.
        pop          = m_data_ok & ~fifo_empty & ~reset;
        inst_data_ok = pop & (fifo_head == OWN_INST);
        data_data_ok = pop & (fifo_head == OWN_DATA);
        inst_rdata   = m_rdata;
        data_rdata   = m_rdata;

        lock_d  = lock_q;
        owner_d = owner;
        if (m_req && !m_addr_ok) begin
            lock_d = 1'b1;
        end else if (m_addr_ok) begin
            lock_d = 1'b0;
        end
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = accept ? owner : last_owner_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q  <= 1'b0;
            owner_q <= OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_DATA;
`endif
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (owner),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(m_data_ok && fifo_empty))
                else $error("sram_like_arbiter: m_data_ok with no outstanding request");
        end
    end
`endif

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;
    import mycpu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, data_req;
    logic [3:0]  inst_wen, data_wen;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req;
    logic [3:0]  m_wen;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.OUTSTANDING(2), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wen(inst_wen), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    // Advance past the next rising edge; inputs are then changed and outputs sampled mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 0;
    endtask

    task automatic test_reset();
        reset = 1; inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h1;
        inst_wen = 0; data_wen = 0; inst_addr = 0; data_addr = 0; inst_wdata = 0; data_wdata = 0;
        next_cycle(); next_cycle(); settle();
        tests++; if (m_req !== 1'b0) begin failed++; $display("FAIL reset_m_req got %b want 0", m_req); end
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin failed++; $display("FAIL reset_addr_ok got %b want 00", {inst_addr_ok, data_addr_ok}); end
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failed++; $display("FAIL reset_data_ok got %b want 00", {inst_data_ok, data_data_ok}); end
        next_cycle(); reset = 0; idle_inputs();
    endtask

    task automatic test_single_read();
        inst_req = 1; inst_addr = 32'hbfc00000; settle();
        tests++; if (m_req !== 1'b1 || m_addr !== 32'hbfc00000) begin failed++; $display("FAIL single_present got req=%b addr=%h want 1/bfc00000", m_req, m_addr); end
        next_cycle(); m_addr_ok = 1; settle();
        tests++; if (inst_addr_ok !== 1'b1) begin failed++; $display("FAIL single_addr_ok got %b want 1", inst_addr_ok); end
        next_cycle(); inst_req = 0; m_addr_ok = 0; settle();
        tests++; if (inst_data_ok !== 1'b0) begin failed++; $display("FAIL single_early_data_ok got %b want 0", inst_data_ok); end
        next_cycle(); m_data_ok = 1; m_rdata = 32'h3c1d0001; settle();
        tests++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3c1d0001) begin failed++; $display("FAIL single_resp got ok=%b rdata=%h want 1/3c1d0001", inst_data_ok, inst_rdata); end
        tests++; if (data_data_ok !== 1'b0) begin failed++; $display("FAIL single_data_quiet got %b want 0", data_data_ok); end
        next_cycle(); idle_inputs();
    endtask

    task automatic test_priority();
        inst_req = 1; inst_addr = 32'h100; inst_wen = 4'h0;
        data_req = 1; data_addr = 32'h200; data_wen = 4'hf; m_addr_ok = 1; settle();
        tests++; if (m_addr !== 32'h200 || m_wen !== 4'hf) begin failed++; $display("FAIL prio_first got addr=%h wen=%h want 200/f", m_addr, m_wen); end
        tests++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin failed++; $display("FAIL prio_first_ok got %b want 01", {inst_addr_ok, data_addr_ok}); end
        next_cycle(); data_req = 0; settle();
        tests++; if (m_addr !== 32'h100 || inst_addr_ok !== 1'b1) begin failed++; $display("FAIL prio_second got addr=%h ok=%b want 100/1", m_addr, inst_addr_ok); end
        next_cycle(); inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hAAAA; settle();
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'hAAAA) begin failed++; $display("FAIL prio_resp1 got ok=%b rdata=%h want 01/aaaa", {inst_data_ok, data_data_ok}, data_rdata); end
        next_cycle(); m_rdata = 32'hBBBB; settle();
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'hBBBB) begin failed++; $display("FAIL prio_resp2 got ok=%b rdata=%h want 10/bbbb", {inst_data_ok, data_data_ok}, inst_rdata); end
        next_cycle(); idle_inputs();
    endtask

    task automatic test_lock();
        inst_req = 1; inst_addr = 32'h300; settle();
        tests++; if (m_req !== 1'b1 || m_addr !== 32'h300) begin failed++; $display("FAIL lock_c0 got req=%b addr=%h want 1/300", m_req, m_addr); end
        next_cycle(); data_req = 1; data_addr = 32'h400; settle();
        tests++; if (m_addr !== 32'h300 || data_addr_ok !== 1'b0) begin failed++; $display("FAIL lock_c1 got addr=%h dok=%b want 300/0", m_addr, data_addr_ok); end
        next_cycle(); settle();
        tests++; if (m_addr !== 32'h300) begin failed++; $display("FAIL lock_c2 got addr=%h want 300", m_addr); end
        next_cycle(); m_addr_ok = 1; settle();
        tests++; if (m_addr !== 32'h300 || {inst_addr_ok, data_addr_ok} !== 2'b10) begin failed++; $display("FAIL lock_accept got addr=%h ok=%b want 300/10", m_addr, {inst_addr_ok, data_addr_ok}); end
        next_cycle(); inst_req = 0; settle();
        tests++; if (m_addr !== 32'h400 || data_addr_ok !== 1'b1) begin failed++; $display("FAIL lock_then_data got addr=%h ok=%b want 400/1", m_addr, data_addr_ok); end
        next_cycle(); data_req = 0; m_addr_ok = 0; m_data_ok = 1; settle();
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin failed++; $display("FAIL lock_resp1 got %b want 10", {inst_data_ok, data_data_ok}); end
        next_cycle(); settle();
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin failed++; $display("FAIL lock_resp2 got %b want 01", {inst_data_ok, data_data_ok}); end
        next_cycle(); idle_inputs();
    endtask

    task automatic test_full();
        inst_req = 1; inst_addr = 32'h10; m_addr_ok = 1; settle();
        tests++; if (inst_addr_ok !== 1'b1) begin failed++; $display("FAIL full_acc1 got %b want 1", inst_addr_ok); end
        next_cycle(); inst_addr = 32'h14; settle();
        tests++; if (inst_addr_ok !== 1'b1) begin failed++; $display("FAIL full_acc2 got %b want 1", inst_addr_ok); end
        next_cycle(); inst_addr = 32'h18; settle();
        tests++; if (m_req !== 1'b0 || inst_addr_ok !== 1'b0) begin failed++; $display("FAIL full_block got req=%b ok=%b want 0/0", m_req, inst_addr_ok); end
        next_cycle(); m_data_ok = 1; m_rdata = 32'h11; settle();
        tests++; if (m_req !== 1'b0 || inst_data_ok !== 1'b1) begin failed++; $display("FAIL full_pop_same got req=%b dok=%b want 0/1", m_req, inst_data_ok); end
        next_cycle(); m_data_ok = 0; settle();
        tests++; if (m_req !== 1'b1 || inst_addr_ok !== 1'b1 || m_addr !== 32'h18) begin failed++; $display("FAIL full_resume got req=%b ok=%b addr=%h want 1/1/18", m_req, inst_addr_ok, m_addr); end
        next_cycle(); inst_req = 0; m_addr_ok = 0; m_data_ok = 1;
        next_cycle(); settle();
        tests++; if (inst_data_ok !== 1'b1) begin failed++; $display("FAIL full_drain got %b want 1", inst_data_ok); end
        next_cycle(); idle_inputs();
    endtask

    task automatic test_reset_midflight();
        inst_req = 1; inst_addr = 32'h20; m_addr_ok = 1;
        next_cycle(); next_cycle();
        reset = 1; data_req = 1; m_data_ok = 1; settle();
        tests++; if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin failed++; $display("FAIL midreset_outputs got %b want 00000", {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        next_cycle(); reset = 0; idle_inputs();
        data_req = 1; data_addr = 32'h500; m_addr_ok = 1; settle();
        tests++; if (data_addr_ok !== 1'b1) begin failed++; $display("FAIL midreset_req got %b want 1", data_addr_ok); end
        next_cycle(); data_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h55; settle();
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'h55) begin failed++; $display("FAIL midreset_resp got ok=%b rdata=%h want 01/55", {inst_data_ok, data_data_ok}, data_rdata); end
        next_cycle(); idle_inputs(); settle();
        tests++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failed++; $display("FAIL midreset_quiet got %b want 00", {inst_data_ok, data_data_ok}); end
    endtask

    // Both masters request every cycle; each grant's response returns one cycle later.
    task automatic test_back_to_back();
        logic exp_own, prev_own;
        prev_own = OWN_INST;
        inst_req = 1; data_req = 1; m_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_own = (i % 2 == 0) ? OWN_INST : OWN_DATA;
`else
            exp_own = OWN_DATA;
`endif
            m_data_ok = (i > 0); settle();
            tests++; if ({inst_addr_ok, data_addr_ok} !== {exp_own == OWN_INST, exp_own == OWN_DATA}) begin failed++; $display("FAIL b2b_grant%0d got %b want inst=%b", i, {inst_addr_ok, data_addr_ok}, exp_own == OWN_INST); end
            if (i > 0) begin
                tests++; if ({inst_data_ok, data_data_ok} !== {prev_own == OWN_INST, prev_own == OWN_DATA}) begin failed++; $display("FAIL b2b_resp%0d got %b", i, {inst_data_ok, data_data_ok}); end
            end
            prev_own = exp_own;
            next_cycle();
        end
        inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 1;
        next_cycle(); idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_lock();
        test_full();
        test_reset_midflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch master and the data (load/store) master. The port feeds the bus bridge.
- Both masters and the slave use the req / addr_ok / data_ok split-handshake protocol already used by the fetch and memory stages.
- Tracks outstanding transactions in order, so each data_ok and rdata is returned only to the master that issued the request.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions (owner FIFO depth, power of 2, ≥1)
- ADDR_W, 32, address and data width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- inst_req  in  1  instruction master request
- inst_wen  in  4  byte write enables (0 = read)
- inst_addr  in  ADDR_W  instruction request address
- inst_wdata  in  ADDR_W  instruction write data
- inst_addr_ok  out  1  instruction request accepted
- inst_data_ok  out  1  instruction response valid
- inst_rdata  out  ADDR_W  instruction read data
- data_req, data_wen, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata  same directions and widths as inst_*, data master
- m_req  out  1  request to slave
- m_wen  out  4  forwarded byte write enables
- m_addr  out  ADDR_W  forwarded address
- m_wdata  out  ADDR_W  forwarded write data
- m_addr_ok  in  1  slave accepted request
- m_data_ok  in  1  slave response valid
- m_rdata  in  ADDR_W  slave read data

Behaviour:
- Clock and reset: reset synchronous, active-high; clock clk. Everything is sampled on the rising edge of clk.
- Reset state:
  - owner FIFO empty; lock cleared; owner = INST.
  - all outputs 0 while reset is high: m_req, *_addr_ok, *_data_ok.
  - Outstanding transactions are discarded; the slave is reset at the same time.
- Grant, no lock active:
  - owner = DATA if data_req, else INST.
  - m_req = (inst_req | data_req) & !fifo_full.
- Lock:
  - Set when m_req=1 and m_addr_ok=0; holds the current owner.
  - While locked, the owner is frozen and m_req = owner's req & !fifo_full.
  - Cleared on the cycle m_addr_ok=1.
  - A request is never switched mid-handshake.
- Muxing: m_wen, m_addr and m_wdata are combinationally muxed from the owner.
- Address acceptance:
  - owner_addr_ok = m_addr_ok & m_req; the other master's addr_ok = 0.
  - On acceptance, push the owner id (1 bit) into the FIFO in the same cycle.
- Response:
  - On m_data_ok, pop the FIFO head and route it.
  - head = DATA: data_data_ok=1, data_rdata=m_rdata.
  - head = INST: the same for inst_*.
  - rdata to the non-selected master = m_rdata; its data_ok = 0.
- Latency: 0-cycle combinational pass-through in both directions; no registering of the address or data paths.
- Full FIFO: m_req forced to 0; masters hold req. A pop in the same cycle does not unblock a push in that cycle.
- Empty FIFO with m_data_ok=1: protocol error. No data_ok is asserted and there is no pop. A simulation assertion fires.
- Simultaneous push and pop (non-full): both happen and the count is unchanged. The pop always refers to an earlier transaction; the slave never returns data_ok in the same cycle as addr_ok of the same request.
- Counter: occupancy counter of width clog2(OUTSTANDING)+1; pointers wrap modulo OUTSTANDING.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: the unlocked grant alternates.
  - A 1-bit last_owner register updates on each acceptance.
  - When both masters request, the one not equal to last_owner wins.
  - last_owner resets to DATA, so INST wins the first tie.
- Undefined: fixed DATA-over-INST priority as above.

Decomposition:
- Shared package mycpu_arb_pkg holds:
  - owner id constants OWN_INST=1'b0 and OWN_DATA=1'b1
  - default OUTSTANDING
- Sub-module arb_owner_fifo: synchronous 1-bit-wide FIFO.
  - Ports: push, pop, din, dout, full, empty.
  - Depth = OUTSTANDING.
  - Instantiated once.

Test Plan:
- Single inst read at 0xbfc00000, slave addr_ok at cycle 1 and data_ok at cycle 3 with rdata 0x3c1d0001 → inst_addr_ok at cycle 1; inst_data_ok=1, inst_rdata=0x3c1d0001 at cycle 3; data_data_ok stays 0.
- inst_req and data_req together, addresses 0x100/0x200, fixed priority → m_addr=0x200 accepted first, then 0x100. Responses 0xAAAA then 0xBBBB go to data then inst respectively.
- Lock: inst_req alone, slave withholds addr_ok for 3 cycles, data_req rises at cycle 1 → m_addr stays on inst for all 3 cycles; data is granted only after inst's addr_ok.
- Full: OUTSTANDING=2, three back-to-back inst reads, no data_ok → third m_req=0. First data_ok → m_req reasserts the next cycle and the third request is accepted.
- Reset mid-flight: two outstanding, reset pulsed → all outputs 0, FIFO empty. A following request completes normally, and a stray m_data_ok right after reset raises no data_ok.
- ARB_ROUND_ROBIN_EN defined, both masters requesting continuously → grants alternate INST, DATA, INST, DATA…
